fetch_buffer: RTL and testbench

- Two-wide instruction queue between fetch and decode; absorbs fetch-pipeline latency and decode backpressure.
- Accepts up to two (pc, instr) pairs per cycle from the fetch output bundle.
- Presents up to two oldest entries in order to decode, first-word-fall-through.
- Raises a stall back to fetch early enough to cover fetch's in-flight bundles.
- Flushes on branch redirect.

---
 rtl/fetch_buffer.sv | 119 +++++++++++
 tb/tb_fetch_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Two-wide instruction queue between fetch and decode. Up to two
//   (pc, instr) pairs are accepted per cycle and packed in slot order.
//   The two oldest entries are shown to decode first-word-fall-through.
//   A registered stall tells fetch to stop early enough to cover its
//   in-flight bundles. A flush (branch redirect) empties the queue.
//
// Ports
//   clk, reset (async, active low)
//   flush                          discard everything, highest priority
//   enq_valid[1:0], enq_pc0/1, enq_instr0/1   fetch bundle
//   fetch_stall                    registered backpressure to fetch
//   deq_valid[1:0], deq_pc0/1, deq_instr0/1   head / head+1 to decode
//   deq_count[1:0]                 entries decode takes this cycle
//   count                          occupancy
//   overflow_err                   sticky: an enqueue slot was dropped
module fetch_buffer #(
  parameter int DEPTH        = 8,
  parameter int PC_W         = 32,
  parameter int INSTR_W      = 32,
  parameter int STALL_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               enq_valid,
  input  logic [PC_W-1:0]          enq_pc0,
  input  logic [PC_W-1:0]          enq_pc1,
  input  logic [INSTR_W-1:0]       enq_instr0,
  input  logic [INSTR_W-1:0]       enq_instr1,
  output logic                     fetch_stall,
  output logic [1:0]               deq_valid,
  output logic [PC_W-1:0]          deq_pc0,
  output logic [PC_W-1:0]          deq_pc1,
  output logic [INSTR_W-1:0]       deq_instr0,
  output logic [INSTR_W-1:0]       deq_instr1,
  input  logic [1:0]               deq_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail;

  logic [1:0]    n_enq, written, deq_avail, deq_eff;
  logic [CW-1:0] free_cnt, next_count;
  logic          drop;
  entry_t        wr0, wr1;
  entry_t        rd [2];

  // Space is judged against the pre-dequeue occupancy; decode's
  // same-cycle consume gives no credit.
  always_comb begin
    n_enq      = 2'(enq_valid[0]) + 2'(enq_valid[1]);
    free_cnt   = CW'(DEPTH) - count;
    drop       = free_cnt < CW'(n_enq);
    // free < n_enq <= 2 means free is 0 or 1, so the low bits are exact
    written    = drop ? free_cnt[1:0] : n_enq;
    deq_avail  = deq_valid[1] ? 2'd2 : {1'b0, deq_valid[0]};
    deq_eff    = (deq_count > deq_avail) ? deq_avail : deq_count;
    next_count = count + CW'(written) - CW'(deq_eff);
    // Compaction: the first written entry is the lowest valid slot.
    wr0        = enq_valid[0] ? {enq_pc0, enq_instr0} : {enq_pc1, enq_instr1};
    wr1        = {enq_pc1, enq_instr1};
  end

  // Entry storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (written != 2'd0) mem[tail]            <= wr0;
      if (written == 2'd2) mem[tail + PW'(1)]   <= wr1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      fetch_stall  <= 1'b0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      fetch_stall <= 1'b0;
    end else begin
      head        <= head + PW'(deq_eff);
      tail        <= tail + PW'(written);
      count       <= next_count;
      fetch_stall <= (CW'(DEPTH) - next_count) < CW'(STALL_MARGIN);
      if (drop) overflow_err <= 1'b1;
    end
  end

  // Read lanes: head and head+1, pointer wrap is natural.
  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign rd[g] = mem[head + PW'(g)];
  end

  assign deq_valid  = {count >= CW'(2), count >= CW'(1)};
  assign deq_pc0    = rd[0].pc;
  assign deq_instr0 = rd[0].instr;
  assign deq_pc1    = rd[1].pc;
  assign deq_instr1 = rd[1].instr;

  // Decode must never take more than it was shown; the RTL clamps anyway.
  a_deq_legal: assert property (@(posedge clk) disable iff (!reset)
    !flush |-> (deq_count <= deq_avail));

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [31:0] enq_pc0, enq_pc1, enq_instr0, enq_instr1;
  logic        fetch_stall;
  logic [1:0]  deq_valid;
  logic [31:0] deq_pc0, deq_pc1, deq_instr0, deq_instr1;
  logic [1:0]  deq_count;
  logic [3:0]  count;
  logic        overflow_err;

  fetch_buffer #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32), .STALL_MARGIN(MARGIN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_pc0(enq_pc0), .enq_pc1(enq_pc1),
    .enq_instr0(enq_instr0), .enq_instr1(enq_instr1),
    .fetch_stall(fetch_stall), .deq_valid(deq_valid),
    .deq_pc0(deq_pc0), .deq_pc1(deq_pc1),
    .deq_instr0(deq_instr0), .deq_instr1(deq_instr1),
    .deq_count(deq_count), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of {pc, instr}, plus two flags.
  logic [63:0] q [$];
  logic        m_ovf, m_stall;
  logic [31:0] npc;
  int          vectors, errs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 64'(count), 64'(q.size()));
    check("deq_valid", 64'(deq_valid), q.size() >= 2 ? 64'd3 : (q.size() == 1 ? 64'd1 : 64'd0));
    check("fetch_stall", 64'(fetch_stall), 64'(m_stall));
    check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    if (q.size() >= 1) check("head0", {deq_pc0, deq_instr0}, q[0]);
    if (q.size() >= 2) check("head1", {deq_pc1, deq_instr1}, q[1]);
  endtask

  // One cycle: check current state, drive, clock, update model.
  task automatic step(input logic [1:0] ev, input logic [1:0] dc, input logic fl);
    logic [63:0] slots [$];
    check_all();
    enq_valid  = ev;
    deq_count  = dc;
    flush      = fl;
    enq_pc0    = ev[0] ? npc : $urandom;
    enq_pc1    = ev[1] ? (ev[0] ? npc + 32'd4 : npc) : $urandom;
    enq_instr0 = $urandom;
    enq_instr1 = $urandom;
    if (!fl) npc = npc + 32'(4 * (int'(ev[0]) + int'(ev[1])));
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_stall = 1'b0;
    end else begin
      if (ev[0]) slots.push_back({enq_pc0, enq_instr0});
      if (ev[1]) slots.push_back({enq_pc1, enq_instr1});
      foreach (slots[i]) begin
        if (q.size() < DEPTH) q.push_back(slots[i]);
        else m_ovf = 1'b1;
      end
      // dc never exceeds the pre-cycle size, so popping after pushing is fine
      repeat (dc) void'(q.pop_front());
      m_stall = (DEPTH - q.size()) < MARGIN;
    end
    @(negedge clk);
  endtask

  initial begin
    int dc_max;
    logic [1:0] ev;
    vectors = 0; errs = 0;
    m_ovf = 0; m_stall = 0; npc = 0;
    reset = 0; flush = 0; enq_valid = 0; deq_count = 0;
    enq_pc0 = 0; enq_pc1 = 0; enq_instr0 = 0; enq_instr1 = 0;
    repeat (2) @(negedge clk);
    check("reset_count", 64'(count), 64'd0);
    check("reset_deq_valid", 64'(deq_valid), 64'd0);
    check("reset_stall", 64'(fetch_stall), 64'd0);
    reset = 1;

    // Fill three bundles, no dequeue.
    step(2'b11, 2'd0, 1'b0);
    check("first_pc0", 64'(deq_pc0), 64'h00);
    check("first_pc1", 64'(deq_pc1), 64'h04);
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    check("fill_count", 64'(count), 64'd6);
    check("fill_stall", 64'(fetch_stall), 64'd1);

    // Drain in pairs.
    check("drain_pc0_a", 64'(deq_pc0), 64'h00);
    step(2'b00, 2'd2, 1'b0);
    check("drain_pc0_b", 64'(deq_pc0), 64'h08);
    step(2'b00, 2'd2, 1'b0);
    check("drain_pc1_c", 64'(deq_pc1), 64'h14);
    step(2'b00, 2'd2, 1'b0);
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid", 64'(deq_valid), 64'd0);
    check("drain_stall", 64'(fetch_stall), 64'd0);

    // Wrap: offset head to an odd slot, then stream pairs through.
    step(2'b01, 2'd0, 1'b0);
    step(2'b11, 2'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(2'b11, 2'd2, 1'b0);
      check("wrap_count_le2", 64'(count <= 4'd2), 64'd1);
    end
    step(2'b00, 2'd2, 1'b0);

    // Odd counts and slot compaction.
    npc = 32'h40;
    step(2'b01, 2'd0, 1'b0);
    check("odd_valid", 64'(deq_valid), 64'd1);
    check("odd_pc0", 64'(deq_pc0), 64'h40);
    step(2'b10, 2'd1, 1'b0);
    check("odd_pc0_b", 64'(deq_pc0), 64'h44);
    step(2'b00, 2'd1, 1'b0);

    // Overflow: fill to 7, then a 2-wide bundle.
    repeat (3) step(2'b11, 2'd0, 1'b0);
    step(2'b01, 2'd0, 1'b0);
    check("ovf_pre_count", 64'(count), 64'd7);
    step(2'b11, 2'd0, 1'b0);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_err", 64'(overflow_err), 64'd1);
    step(2'b00, 2'd0, 1'b1);
    check("ovf_after_flush", 64'(overflow_err), 64'd1);

    // Flush with count=5 and competing enqueue/dequeue.
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    step(2'b01, 2'd0, 1'b0);
    check("flush_pre_count", 64'(count), 64'd5);
    step(2'b11, 2'd2, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(deq_valid), 64'd0);
    check("flush_stall", 64'(fetch_stall), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      ev = 2'($urandom);
      dc_max = q.size() >= 2 ? 2 : q.size();
      step(ev, 2'($urandom_range(dc_max, 0)), ($urandom_range(24, 0) == 0));
    end

    // Async reset in the middle of a cycle, between edges.
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    enq_valid = 2'b11;
    #2 reset = 0;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_valid", 64'(deq_valid), 64'd0);
    check("async_stall", 64'(fetch_stall), 64'd0);
    check("async_ovf", 64'(overflow_err), 64'd0);
    q.delete(); m_ovf = 0; m_stall = 0;
    @(negedge clk);
    reset = 1;
    step(2'b11, 2'd0, 1'b0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
